// File: rtl/tmp10x_pkg.sv
// Shared types and constants for the TMP10X polling sequencer.
package tmp10x_pkg;

  typedef enum logic [2:0] {
    ST_CFG_WR = 3'd0,
    ST_PTR_WR = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RD     = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  typedef enum logic {
    PH_REQ  = 1'b0,
    PH_XFER = 1'b1
  } phase_t;

  localparam logic [7:0] PTR_TEMP = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;
  localparam int         TEMP_W   = 12;

endpackage

// File: rtl/tmp10x_alert_cmp.sv
// Hysteresis over-temperature comparator; only built when TMP_ALERT_EN is defined.
`ifdef TMP_ALERT_EN
module tmp10x_alert_cmp
  import tmp10x_pkg::*;
#(
  parameter logic [TEMP_W-1:0] T_HIGH = 12'h500,
  parameter logic [TEMP_W-1:0] T_LOW  = 12'h4B0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic [TEMP_W-1:0] temperature,
  output logic              alert
);

  // Set above T_HIGH, clear below T_LOW, hold in the band between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alert <= 1'b0;
    end else if (sample) begin
      if ($signed(temperature) > $signed(T_HIGH)) begin
        alert <= 1'b1;
      end else if ($signed(temperature) < $signed(T_LOW)) begin
        alert <= 1'b0;
      end else begin
        alert <= alert;
      end
    end else begin
      alert <= alert;
    end
  end

endmodule
`endif

// File: rtl/tmp10x_poll_ctrl.sv
// TMP10X polling sequencer driving an I2C master: configure, set pointer, poll reads.
// Optional hysteresis alert output is enabled with the TMP_ALERT_EN macro.
module tmp10x_poll_ctrl
  import tmp10x_pkg::*;
#(
  parameter int                       ADDRESSLENGTH = 8,
  parameter logic [ADDRESSLENGTH-1:0] SLAVE_ADDR    = 8'h48,
  parameter logic [7:0]               CFG_VALUE     = 8'h60,
  parameter int                       POLL_PERIOD   = 1000,
  parameter int                       MAX_RETRY     = 3,
  parameter logic [TEMP_W-1:0]        T_HIGH        = 12'h500,
  parameter logic [TEMP_W-1:0]        T_LOW         = 12'h4B0
) (
  input  logic                     Clk,
  input  logic                     RST,
  output logic                     m_start,
  output logic                     m_rorw,
  output logic [ADDRESSLENGTH-1:0] m_addr,
  output logic [3:0]               m_nbytes,
  output logic [7:0]               m_tx_data,
  input  logic                     m_tx_ack,
  input  logic [7:0]               m_rx_data,
  input  logic                     m_rx_valid,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic                     m_nack,
  output logic [TEMP_W-1:0]        temperature,
  output logic                     temp_valid,
  output logic                     err,
  output logic                     alert
);

  localparam int CNT_W = $clog2(POLL_PERIOD + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  state_t           state_r;
  phase_t           phase_r;
  logic             idx_r;
  logic [1:0]       rx_cnt_r;
  logic [7:0]       msb_r;
  logic [3:0]       lsb_hi_r;
  logic [RTY_W-1:0] retry_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             unused_rx_low;

  function automatic logic [7:0] tx_byte(input state_t st, input logic idx);
    case (st)
      ST_CFG_WR: tx_byte = idx ? CFG_VALUE : PTR_CFG;
      ST_PTR_WR: tx_byte = PTR_TEMP;
      default:   tx_byte = PTR_TEMP;
    endcase
  endfunction

  assign m_addr        = SLAVE_ADDR;
  assign unused_rx_low = ^m_rx_data[3:0];

  // Sequencer: transaction states split into REQ/XFER phases, retry and poll timing.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_r     <= ST_CFG_WR;
      phase_r     <= PH_REQ;
      m_start     <= 1'b0;
      m_rorw      <= 1'b1;
      m_nbytes    <= 4'd2;
      m_tx_data   <= PTR_CFG;
      idx_r       <= 1'b0;
      rx_cnt_r    <= 2'd0;
      msb_r       <= 8'h00;
      lsb_hi_r    <= 4'h0;
      retry_r     <= '0;
      wait_cnt_r  <= '0;
      temperature <= '0;
      temp_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      case (state_r)
        ST_CFG_WR, ST_PTR_WR, ST_RD: begin
          if (phase_r == PH_REQ) begin
            if (m_start && m_busy) begin
              m_start <= 1'b0;
              phase_r <= PH_XFER;
            end else begin
              m_start <= 1'b1;
            end
          end else begin
            // Only the two-byte config write has a second byte to advance to.
            if (m_tx_ack && (state_r == ST_CFG_WR) && !idx_r) begin
              idx_r     <= 1'b1;
              m_tx_data <= CFG_VALUE;
            end
            if (m_rx_valid && (state_r == ST_RD)) begin
              if (rx_cnt_r == 2'd0) begin
                msb_r <= m_rx_data;
              end else if (rx_cnt_r == 2'd1) begin
                lsb_hi_r <= m_rx_data[7:4];
              end
              if (rx_cnt_r != 2'd3) begin
                rx_cnt_r <= rx_cnt_r + 2'd1;
              end
            end
            if (m_done) begin
              phase_r  <= PH_REQ;
              idx_r    <= 1'b0;
              rx_cnt_r <= 2'd0;
              if (!m_nack && ((state_r != ST_RD) || (rx_cnt_r == 2'd2))) begin
                retry_r <= '0;
                case (state_r)
                  ST_CFG_WR: begin
                    state_r   <= ST_PTR_WR;
                    m_start   <= 1'b1;
                    m_nbytes  <= 4'd1;
                    m_tx_data <= PTR_TEMP;
                  end
                  ST_PTR_WR: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= CNT_W'(POLL_PERIOD - 1);
                  end
                  default: begin
                    state_r     <= ST_WAIT;
                    wait_cnt_r  <= CNT_W'(POLL_PERIOD - 1);
                    temperature <= {msb_r, lsb_hi_r};
                    temp_valid  <= 1'b1;
                  end
                endcase
              end else if (retry_r == RTY_W'(MAX_RETRY)) begin
                state_r <= ST_ERROR;
                err     <= 1'b1;
                m_start <= 1'b0;
              end else begin
                retry_r   <= retry_r + 1'b1;
                m_start   <= 1'b1;
                m_tx_data <= tx_byte(state_r, 1'b0);
              end
            end
          end
        end
        ST_WAIT: begin
          // Count reaches 1 so that m_start is high POLL_PERIOD cycles after m_done.
          if (wait_cnt_r == CNT_W'(1)) begin
            state_r   <= ST_RD;
            phase_r   <= PH_REQ;
            m_start   <= 1'b1;
            m_rorw    <= 1'b0;
            m_nbytes  <= 4'd2;
            m_tx_data <= PTR_TEMP;
            idx_r     <= 1'b0;
            rx_cnt_r  <= 2'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_W'(1);
          end
        end
        ST_ERROR: begin
          m_start <= 1'b0;
          err     <= 1'b1;
        end
        default: begin
          state_r <= ST_ERROR;
          m_start <= 1'b0;
          err     <= 1'b1;
        end
      endcase
    end
  end

`ifdef TMP_ALERT_EN
  tmp10x_alert_cmp #(
    .T_HIGH (T_HIGH),
    .T_LOW  (T_LOW)
  ) u_alert_cmp (
    .clk         (Clk),
    .rst         (RST),
    .sample      (temp_valid),
    .temperature (temperature),
    .alert       (alert)
  );
`else
  logic unused_thresholds;
  assign unused_thresholds = ^{T_HIGH, T_LOW};
  assign alert             = 1'b0;
`endif

endmodule

// File: tb/tb_tmp10x_poll_ctrl.sv
// Directed-sequence bench with a randomized I2C master model and a reference model.
`timescale 1ns/1ps
module tb_tmp10x_poll_ctrl;

  localparam int         P    = 10;
  localparam int         MAXR = 3;
  localparam logic [7:0] CFG  = 8'h60;

  logic        Clk = 1'b0;
  logic        RST = 1'b1;
  logic        m_tx_ack = 1'b0, m_rx_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0]  m_rx_data = 8'h00;
  logic        m_start, m_rorw, temp_valid, err, alert;
  logic [7:0]  m_addr, m_tx_data;
  logic [3:0]  m_nbytes;
  logic [11:0] temperature;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  logic        prev_start = 1'b0;
  logic [7:0]  tx_q[$];
  logic [11:0] temp_m = 12'h000;
  logic        alert_m = 1'b0;
  logic        err_m = 1'b0;
  int          fails_m = 0;

  tmp10x_poll_ctrl #(
    .ADDRESSLENGTH(8), .SLAVE_ADDR(8'h48), .CFG_VALUE(CFG), .POLL_PERIOD(P),
    .MAX_RETRY(MAXR), .T_HIGH(12'h500), .T_LOW(12'h4B0)
  ) dut (
    .Clk(Clk), .RST(RST), .m_start(m_start), .m_rorw(m_rorw), .m_addr(m_addr),
    .m_nbytes(m_nbytes), .m_tx_data(m_tx_data), .m_tx_ack(m_tx_ack),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_busy(m_busy),
    .m_done(m_done), .m_nack(m_nack), .temperature(temperature),
    .temp_valid(temp_valid), .err(err), .alert(alert)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    if (m_start && !prev_start) rise_cyc = cyc;
    prev_start = m_start;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, m_start, 0);
    chk({tag, "_rorw"}, m_rorw, 1);
    chk({tag, "_nbytes"}, m_nbytes, 2);
    chk({tag, "_txdata"}, m_tx_data, 8'h01);
    chk({tag, "_temp"}, temperature, 0);
    chk({tag, "_tvalid"}, temp_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_alert"}, alert, 0);
  endtask

  // Apply the sensor's rules to a completed read attempt.
  task automatic model_read(input bit ok, input logic [7:0] msb, input logic [7:0] lsb);
    int ts;
    if (ok) begin
      fails_m = 0;
      temp_m  = 12'((int'(msb) * 16) + (int'(lsb) / 16));
      ts = (temp_m >= 12'd2048) ? int'(temp_m) - 4096 : int'(temp_m);
`ifdef TMP_ALERT_EN
      if (ts > 1280) alert_m = 1'b1;
      else if (ts < 1200) alert_m = 1'b0;
`endif
    end else begin
      fails_m++;
      if (fails_m > MAXR) err_m = 1'b1;
    end
  endtask

  task automatic txn(input bit nack, input bit short_rd, input logic [7:0] b0,
                     input logic [7:0] b1, input int exp_rise, input bit exp_rorw,
                     input int exp_n, output int done_cyc);
    int n = 0;
    while (!m_start && n < 400) begin tick(); n++; end
    chk("start_seen", m_start, 1);
    if (exp_rise >= 0) chk("start_latency", rise_cyc, exp_rise);
    chk("rorw", m_rorw, exp_rorw);
    chk("nbytes", m_nbytes, exp_n);
    chk("addr", m_addr, 8'h48);
    repeat ($urandom_range(0, 2)) tick();
    m_busy = 1'b1;
    tick();
    chk("start_drop", m_start, 0);
    tx_q.delete();
    if (exp_rorw) begin
      for (int i = 0; i <= exp_n; i++) begin
        tx_q.push_back(m_tx_data);
        m_tx_ack = 1'b1;
        tick();
        m_tx_ack = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
      end
    end else begin
      m_rx_data = b0; m_rx_valid = 1'b1;
      tick();
      if (!short_rd) begin m_rx_data = b1; tick(); end
      m_rx_valid = 1'b0; m_rx_data = 8'($urandom);
      tick();
    end
    m_nack = nack; m_done = 1'b1; done_cyc = cyc;
    tick();
    m_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0;
  endtask

  task automatic chk_cfg_bytes();
    chk("cfg_count", tx_q.size(), 3);
    if (tx_q.size() == 3) begin
      chk("cfg_b0", tx_q[0], 8'h01);
      chk("cfg_b1", tx_q[1], CFG);
      chk("cfg_hold", tx_q[2], CFG);
    end
  endtask

  task automatic chk_ptr_bytes();
    chk("ptr_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      chk("ptr_b0", tx_q[0], 8'h00);
      chk("ptr_hold", tx_q[1], 8'h00);
    end
  endtask

  initial begin
    int         d, r, exp_rise, n, quiet;
    bit         prev_ok;
    logic [7:0] msb, lsb;
    int         kind[10]    = '{0, 0, 1, 0, 0, 2, 0, 0, 0, 0};
    logic [7:0] msb_t[10]   = '{8'hCC, 8'h51, 8'h00, 8'h4C, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] lsb_t[10]   = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) tick();
    chk_reset("reset");
    RST = 1'b0; r = cyc;

    txn(0, 0, 8'h00, 8'h00, r + 1, 1, 2, d);
    chk_cfg_bytes();
    chk("err_after_cfg", err, 0);

    // Pointer write NACKed once, then accepted.
    txn(1, 0, 8'h00, 8'h00, -1, 1, 1, d);
    chk_ptr_bytes();
    chk("err_after_ptr_nack", err, 0);
    txn(0, 0, 8'h00, 8'h00, d + 1, 1, 1, d);
    chk_ptr_bytes();
    prev_ok = 1'b1;

    for (int i = 0; i < 10; i++) begin
      msb = (i < 6) ? msb_t[i] : 8'($urandom_range(0, 255));
      lsb = (i < 6) ? lsb_t[i] : 8'($urandom_range(0, 255));
      exp_rise = prev_ok ? d + P : d + 1;
      txn(kind[i] == 1, kind[i] == 2, msb, lsb, exp_rise, 0, 2, d);
      model_read(kind[i] == 0, msb, lsb);
      prev_ok = (kind[i] == 0);
      chk("rd_tvalid", temp_valid, prev_ok);
      chk("rd_temp", temperature, temp_m);
      chk("rd_err", err, err_m);
      tick();
      chk("rd_tvalid_end", temp_valid, 0);
      chk("rd_alert", alert, alert_m);
    end

    // Reset in the middle of a read restarts the whole sequence.
    n = 0;
    while (!m_start && n < 400) begin tick(); n++; end
    chk("midrd_start_seen", m_start, 1);
    m_busy = 1'b1;
    tick();
    m_rx_data = 8'h7F; m_rx_valid = 1'b1;
    tick();
    m_rx_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk_reset("midrd");
    temp_m = 12'h000; alert_m = 1'b0; fails_m = 0;
    m_busy = 1'b0;
    tick(); tick();
    RST = 1'b0; r = cyc;
    txn(0, 0, 8'h00, 8'h00, r + 1, 1, 2, d);
    chk_cfg_bytes();
    txn(0, 0, 8'h00, 8'h00, -1, 1, 1, d);
    chk_ptr_bytes();

    // Four NACKed reads in a row exhaust the retry budget.
    exp_rise = d + P;
    for (int k = 0; k < 4; k++) begin
      txn(1, 0, 8'($urandom), 8'($urandom), exp_rise, 0, 2, d);
      model_read(1'b0, 8'h00, 8'h00);
      chk("nack_err", err, err_m);
      chk("nack_temp", temperature, temp_m);
      exp_rise = d + 1;
    end
    chk("err_start_low", m_start, 0);
    quiet = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (m_start) quiet++;
    end
    chk("err_start_quiet", quiet, 0);
    chk("err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
